// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch path and
//   the load/store data path. One access is in flight at a time and is
//   sequenced IDLE -> ISSUE -> WAIT (MEM_LATENCY-1 cycles) -> RESP.
//   Data requests win by default; a pending fetch is forced through after
//   STARVE_LIMIT consecutive data grants.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   if_req/if_addr             fetch request and PC
//   if_gnt/if_rvalid/if_rdata  fetch accept, response pulse, instruction word
//   d_req/d_we/d_addr/d_wdata  load/store request
//   d_gnt/d_rvalid/d_rdata     data accept, response pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   stall                      freeze PC while a fetch is outstanding
//   busy                       an access is in flight
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  // WAIT counts down to zero, so it is loaded with (latency - 2).
  localparam logic [3:0] WAIT_LOAD  = (MEM_LATENCY >= 2) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [3:0]            starve_q, starve_d;
  logic                  owner_q;   // 1 = data path owns the access
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  fetch_first;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt || d_gnt) state_d = ISSUE;
      end
      ISSUE: begin
        if (MEM_LATENCY == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) state_d = RESP;
        else                wait_d  = wait_q - 4'd1;
      end
      RESP: begin
        state_d = (if_gnt || d_gnt) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Starvation only accumulates while a fetch is actually waiting.
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Output logic
  always_comb begin
    fetch_first = if_req && (!d_req || (starve_q == STARVE_MAX));
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if (!reset && ((state_q == IDLE) || (state_q == RESP))) begin
      if_gnt = fetch_first;
      d_gnt  = d_req && !fetch_first;
    end
    mem_en    = (state_q == ISSUE);
    mem_we    = (state_q == ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rvalid = (state_q == RESP) && !owner_q;
    d_rvalid  = (state_q == RESP) && owner_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state_q != IDLE);
    stall     = !reset && if_req && !if_rvalid;
  end

  // Request capture on grant and read-data return on entry to RESP.
  // mem_wdata keeps its last store value across fetches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_gnt || d_gnt) begin
        owner_q <= d_gnt;
        we_q    <= d_gnt && d_we;
        addr_q  <= d_gnt ? d_addr : if_addr;
        if (d_gnt) wdata_q <= d_wdata;
      end
      if ((state_d == RESP) && (state_q != RESP) && !we_q) begin
        if (owner_q) d_rdata_q  <= mem_rdata;
        else         if_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: DUT 0 runs with MEM_LATENCY=1, DUT 1 with
// MEM_LATENCY=3, both STARVE_LIMIT=4. Each DUT has its own memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic [1:0] reset, if_req, d_req, d_we;
  logic [1:0][31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0] if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall, busy;
  logic [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] last_d [2];

  typedef struct {int dut; bit d; logic [31:0] data; int cyc;} rsp_t;
  typedef struct {int dut; bit we; logic [31:0] addr; logic [31:0] wdata; int cyc;} mem_t;
  rsp_t rq[$];
  mem_t mq[$];

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .stall(stall[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .stall(stall[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: word i holds 0xA000_0000 + i, except 0x200 in memory 1.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  bit mem_ready = 1'b0;
  assign mem_rdata[0] = mem0[mem_addr[0][9:2]];
  assign mem_rdata[1] = mem1[mem_addr[1][9:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 32'hA000_0000 + i;
        mem1[i] <= 32'hA000_0000 + i;
      end
      mem1[128] <= 32'h1234_5678;
      mem_ready <= 1'b1;
    end else begin
      if (mem_en[0] && mem_we[0]) mem0[mem_addr[0][9:2]] <= mem_wdata[0];
      if (mem_en[1] && mem_we[1]) mem1[mem_addr[1][9:2]] <= mem_wdata[1];
    end
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input int k, input string name);
    check({name, "_ctrl"}, {if_gnt[k], if_rvalid[k], d_gnt[k], d_rvalid[k],
                            mem_en[k], mem_we[k], stall[k], busy[k]}, 0);
    check({name, "_data"}, if_rdata[k] | d_rdata[k] | mem_addr[k] | mem_wdata[k], 0);
  endtask

  // Grant in cycle t: memory access expected at t+1, response at t+1+latency.
  task automatic push_exp(input int k, input bit d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] data, input int t);
    mem_t m;
    rsp_t r;
    m.dut = k; m.we = we; m.addr = addr; m.wdata = wdata; m.cyc = t + 1;
    mq.push_back(m);
    r.dut = k; r.d = d; r.cyc = t + 1 + lat(k);
    if (d && we) r.data = last_d[k];
    else begin
      r.data = data;
      if (d) last_d[k] = data;
    end
    rq.push_back(r);
  endtask

  task automatic req(input int k, input bit d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] data, output int t);
    bit got;
    got = 1'b0;
    t = -1;
    if (d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = d ? d_gnt[k] : if_gnt[k];
    end
    if (!got) check("gnt_timeout", got, 1);
    else begin
      t = cyc;
      push_exp(k, d, d && we, addr, wdata, data, t);
    end
    @(posedge clk); #1;
    if (d) d_req[k] = 1'b0;
    else   if_req[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (if_gnt[k] || d_gnt[k]) check("gnt_onehot", if_gnt[k] & d_gnt[k], 0);
      if (if_rvalid[k] || d_rvalid[k]) begin
        int idx;
        idx = -1;
        foreach (rq[i]) if (idx < 0 && rq[i].dut == k) idx = i;
        if (idx < 0) check("rsp_unexpected", {if_rvalid[k], d_rvalid[k]}, 0);
        else begin
          rsp_t e;
          e = rq[idx];
          rq.delete(idx);
          check("rsp_owner", {if_rvalid[k], d_rvalid[k]}, e.d ? 2'b01 : 2'b10);
          check("rsp_data", e.d ? d_rdata[k] : if_rdata[k], e.data);
          check("rsp_cycle", cyc, e.cyc);
        end
      end
      if (mem_en[k]) begin
        int idx;
        idx = -1;
        foreach (mq[i]) if (idx < 0 && mq[i].dut == k) idx = i;
        if (idx < 0) check("mem_unexpected", mem_en[k], 0);
        else begin
          mem_t e;
          e = mq[idx];
          mq.delete(idx);
          check("mem_we", mem_we[k], e.we);
          check("mem_addr", mem_addr[k], e.addr);
          if (e.we) check("mem_wdata", mem_wdata[k], e.wdata);
          check("mem_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, td, tf, tf1, tf2, trel;
    int tds [8];
    bit got;
    last_d[0] = '0;
    last_d[1] = '0;
    reset = 2'b11;
    if_req = 2'b11; d_req = 2'b11; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    #2;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    if_req = '0; d_req = '0;
    idle(3);
    reset = 2'b00;
    idle(2);

    // Single fetch, latency 1, requester held through RESP (regranted there).
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    @(negedge clk);
    t = cyc;
    check("f1_gnt", if_gnt[0], 1);
    check("f1_stall_T", stall[0], 1);
    push_exp(0, 0, 0, 32'h40, 0, 32'hA000_0010, t);
    @(negedge clk);
    check("f1_stall_T1", stall[0], 1);
    check("f1_busy", busy[0], 1);
    @(negedge clk);
    check("f1_stall_T2", stall[0], 0);
    check("f1_regnt", if_gnt[0], 1);
    push_exp(0, 0, 0, 32'h40, 0, 32'hA000_0010, cyc);
    @(posedge clk); #1;
    if_req[0] = 1'b0;
    idle(4);

    // Simultaneous requests: store first, fetch granted in the store's RESP.
    fork
      req(0, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, td);
      req(0, 0, 0, 32'h44, 0, 32'hA000_0011, tf);
    join
    check("simul_fetch_after_store", tf - td, 2);
    idle(4);

    // Starvation: continuous requests give a 4:1 data/fetch pattern.
    fork
      begin
        for (int i = 0; i < 8; i++) req(0, 1, 1, 32'h300 + 4 * i, i, 0, tds[i]);
      end
      begin
        req(0, 0, 0, 32'h48, 0, 32'hA000_0012, tf1);
        req(0, 0, 0, 32'h4C, 0, 32'hA000_0013, tf2);
      end
    join
    check("starve_d4_span", tds[3] - tds[0], 6);
    check("starve_f1", tf1 - tds[0], 8);
    check("starve_d5", tds[4] - tf1, 2);
    check("starve_f2", tf2 - tds[4], 8);
    idle(4);

    // Latency 3: load, store (d_rdata unchanged), load back the stored word.
    req(1, 1, 0, 32'h200, 0, 32'h1234_5678, t);
    req(1, 1, 1, 32'h204, 32'h55, 0, t);
    idle(8);
    check("d_rdata_hold", d_rdata[1], 32'h1234_5678);
    req(1, 1, 0, 32'h204, 0, 32'h55, t);
    req(1, 0, 0, 32'h100, 0, 32'hA000_0040, t);
    idle(8);

    // Reset during WAIT abandons the access.
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h208;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = d_gnt[1];
    end
    check("rst_test_gnt", got, 1);
    t = cyc;
    mq.push_back('{dut: 1, we: 1'b0, addr: 32'h208, wdata: 32'h0, cyc: t + 1});
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_rst", busy[1], 1);
    reset[1] = 1'b1;
    #1;
    chk_zero(1, "rst_mid");
    idle(2);
    reset[1] = 1'b0;
    trel = cyc;
    req(1, 0, 0, 32'h40, 0, 32'hA000_0010, t);
    check("rst_first_gnt", t, trel);
    idle(10);

    check("rsp_q_empty", rq.size(), 0);
    check("mem_q_empty", mq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
